wbu_busarb: RTL

- Two-master Wishbone (pipelined, B4-style stall) arbiter that shares one slave bus between the debug-bus master (port A, the wbubus command path) and a second master (port B, e.g. the CPU).
- Ownership is held for a master's entire CYC; the grant changes only when the bus is idle.
- Sits between the masters and the interconnect/watchdog.

---
 rtl/wbu_busarb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wbu_busarb.sv
// Two-master pipelined Wishbone arbiter: the debug bus (A) and a second master (B) share one slave bus.
// Optional bus-timeout abort is built only when WBA_TIMEOUT_EN is defined.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   IDLE     | no owner; arbitrate, both masters see stall
//   OWN_A    | master A owns the slave bus for its whole CYC
//   OWN_B    | master B owns the slave bus for its whole CYC
//   ABORT    | timed-out owner held off until it drops CYC
module wbu_busarb #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int LGTIMEOUT = 19
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_ack,
  output logic          o_a_stall,
  output logic          o_a_err,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_ack,
  output logic          o_b_stall,
  output logic          o_b_err,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data,
  output logic [1:0]    o_grant
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic       own_a, own_b;
  logic       act_a, act_b;
  logic       tmo_hit;

  // Read data goes to the masters outside this block.
  logic unused_rd;
  assign unused_rd = ^i_wb_data;

  assign own_a = (state_q == ST_OWN_A);
  assign own_b = (state_q == ST_OWN_B);
  assign act_a = own_a & i_a_cyc;
  assign act_b = own_b & i_b_cyc;

  assign o_wb_cyc  = act_a | act_b;
  assign o_wb_stb  = (act_a & i_a_stb) | (act_b & i_b_stb);
  assign o_wb_we   = (act_a & i_a_we) | (act_b & i_b_we);
  assign o_wb_addr = own_b ? i_b_addr : i_a_addr;
  assign o_wb_data = own_b ? i_b_data : i_a_data;

  assign o_a_stall = own_a ? (i_wb_stall | tmo_hit) : 1'b1;
  assign o_b_stall = own_b ? (i_wb_stall | tmo_hit) : 1'b1;
  assign o_a_ack   = act_a & i_wb_ack;
  assign o_b_ack   = act_b & i_wb_ack;
  assign o_a_err   = act_a & (i_wb_err | tmo_hit);
  assign o_b_err   = act_b & (i_wb_err | tmo_hit);

  assign o_grant = {own_b, own_a};

`ifdef WBA_TIMEOUT_EN
  // Down-counter reloaded to all-ones; terminal count at zero matches
  // 2**LGTIMEOUT-1 cycles of an owned, unanswered CYC.
  logic [LGTIMEOUT-1:0] tmo_q, tmo_d;

  assign tmo_hit = o_wb_cyc & (tmo_q == '0);

  always_comb begin
    tmo_d = tmo_q;
    if ((state_q == ST_IDLE) || i_wb_ack || i_wb_err || (state_d != state_q))
      tmo_d = '1;
    else if (o_wb_cyc)
      tmo_d = tmo_q - 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      tmo_q <= '1;
    else
      tmo_q <= tmo_d;
  end
`else
  logic [LGTIMEOUT-1:0] unused_tmo;
  assign unused_tmo = '0;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (i_a_cyc && (!i_b_cyc || (last_q == LAST_B)))
          state_d = ST_OWN_A;
        else if (i_b_cyc)
          state_d = ST_OWN_B;
      end
      ST_OWN_A: begin
        if (!i_a_cyc) begin
          state_d = ST_IDLE;
          last_d  = LAST_A;
        end else if (tmo_hit) begin
          state_d = ST_ABORT;
          last_d  = LAST_A;
        end
      end
      ST_OWN_B: begin
        if (!i_b_cyc) begin
          state_d = ST_IDLE;
          last_d  = LAST_B;
        end else if (tmo_hit) begin
          state_d = ST_ABORT;
          last_d  = LAST_B;
        end
      end
      ST_ABORT: begin
        // last_q names the aborted owner while in ABORT.
        if ((last_q == LAST_A) ? !i_a_cyc : !i_b_cyc)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_B;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule
